// File: rtl/exp_taylor_unit_pkg.sv
// Shared constants, FSM states and fp32 arithmetic
// helpers for the Taylor-series exponential unit.
package exp_pkg;

  localparam logic [31:0] ONE     = 32'h3F80_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] OVF_TH  = 32'h42B0_0000;
  localparam logic [31:0] UNF_TH  = 32'hC2AE_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_MUL_X,
    S_MUL_P,
    S_ADD_1,
    S_DONE
  } state_t;

  function automatic logic [31:0] inv_rom(
    input logic [3:0] k
  );
    logic [31:0] v;
    case (k)
      4'd1:    v = 32'h3F80_0000;
      4'd2:    v = 32'h3F00_0000;
      4'd3:    v = 32'h3EAA_AAAB;
      4'd4:    v = 32'h3E80_0000;
      4'd5:    v = 32'h3E4C_CCCD;
      4'd6:    v = 32'h3E2A_AAAB;
      4'd7:    v = 32'h3E12_4925;
      4'd8:    v = 32'h3E00_0000;
      default: v = 32'h3F80_0000;
    endcase
    return v;
  endfunction

  // Denormals flush to zero; specials never reach here.
  function automatic logic [31:0] fp_mul(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic              s;
    logic [47:0]       pr;
    logic [24:0]       m;
    logic              rb;
    logic              sb;
    logic signed [9:0] e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
      return {s, 31'd0};
    pr = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]})
      + $signed({2'b00, b[30:23]})
      - 10'sd127;
    if (pr[47]) begin
      m  = {1'b0, pr[47:24]};
      rb = pr[23];
      sb = |pr[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = {1'b0, pr[46:23]};
      rb = pr[22];
      sb = |pr[21:0];
    end
    if (rb && (sb || m[0]))
      m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255)
      return {s, 8'hFF, 23'd0};
    if (e <= 10'sd0)
      return {s, 31'd0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(
    input logic [31:0] a_in,
    input logic [31:0] b_in
  );
    logic [31:0]       a;
    logic [31:0]       b;
    logic [26:0]       ma;
    logic [26:0]       mb;
    logic [26:0]       n;
    logic [27:0]       sum;
    logic [7:0]        d;
    logic [24:0]       m;
    logic signed [9:0] e;
    if (a_in[30:23] == 8'd0)
      return (b_in[30:23] == 8'd0) ? 32'd0 : b_in;
    if (b_in[30:23] == 8'd0)
      return a_in;
    if (b_in[30:0] > a_in[30:0]) begin
      a = b_in;
      b = a_in;
    end else begin
      a = a_in;
      b = b_in;
    end
    ma = {1'b1, a[22:0], 3'b000};
    mb = {1'b1, b[22:0], 3'b000};
    d  = a[30:23] - b[30:23];
    // Bits shifted out fold into the sticky lsb.
    if (d > 8'd26) begin
      mb = 27'd1;
    end else begin
      n = mb >> d;
      if ((mb & ((27'd1 << d) - 27'd1)) != 27'd0)
        n[0] = 1'b1;
      mb = n;
    end
    e = $signed({2'b00, a[30:23]});
    if (a[31] == b[31]) begin
      sum = {1'b0, ma} + {1'b0, mb};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e   = e + 10'sd1;
      end
      n = sum[26:0];
    end else begin
      n = ma - mb;
      if (n == 27'd0)
        return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!n[26]) begin
          n = n << 1;
          e = e - 10'sd1;
        end
      end
    end
    m = {1'b0, n[26:3]};
    if (n[2] && (n[1] || n[0] || n[3]))
      m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255)
      return {a[31], 8'hFF, 23'd0};
    if (e <= 10'sd0)
      return {a[31], 31'd0};
    return {a[31], e[7:0], m[22:0]};
  endfunction

endpackage

// File: rtl/exp_taylor_unit_fp_op_seq.sv
// One strobe/ack unit transaction sequencer, plus the
// strobe/ack fp32 arithmetic unit it drives.
module fp_op_seq (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        i_go,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic        o_a_stb,
  output logic        o_b_stb,
  input  logic        i_a_ack,
  input  logic        i_b_ack,
  input  logic [31:0] i_z,
  input  logic        i_z_stb,
  output logic        o_z_ack,
  output logic [31:0] o_z,
  output logic        o_done
);

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_z;
  logic        r_a_stb;
  logic        r_b_stb;
  logic        r_z_ack;
  logic        r_done;
  logic        r_busy;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_z     <= '0;
      r_a_stb <= 1'b0;
      r_b_stb <= 1'b0;
      r_z_ack <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_z_ack <= 1'b0;
      r_done  <= 1'b0;
      if (i_go && !r_busy) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_a_stb <= 1'b1;
        r_b_stb <= 1'b1;
        r_busy  <= 1'b1;
      end else begin
        if (r_a_stb && i_a_ack)
          r_a_stb <= 1'b0;
        if (r_b_stb && i_b_ack)
          r_b_stb <= 1'b0;
        if (r_busy && i_z_stb &&
            !r_a_stb && !r_b_stb) begin
          r_z     <= i_z;
          r_z_ack <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_a_stb = r_a_stb;
  assign o_b_stb = r_b_stb;
  assign o_z_ack = r_z_ack;
  assign o_z     = r_z;
  assign o_done  = r_done;

endmodule

module fp_unit #(
  parameter bit IS_ADD = 1'b0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] i_a,
  input  logic        i_a_stb,
  output logic        o_a_ack,
  input  logic [31:0] i_b,
  input  logic        i_b_stb,
  output logic        o_b_ack,
  output logic [31:0] o_z,
  output logic        o_z_stb,
  input  logic        i_z_ack
);
  import exp_pkg::*;

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_z;
  logic        r_a_ack;
  logic        r_b_ack;
  logic        r_got_a;
  logic        r_got_b;
  logic        r_run;
  logic        r_z_stb;
  logic [1:0]  r_cnt;
  logic [31:0] w_res;

  always_comb begin
    w_res = fp_mul(r_a, r_b);
    if (IS_ADD)
      w_res = fp_add(r_a, r_b);
  end

  // Latency varies with operand low bits.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_z     <= '0;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      r_got_a <= 1'b0;
      r_got_b <= 1'b0;
      r_run   <= 1'b0;
      r_z_stb <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      if (i_a_stb && !r_got_a && !r_z_stb) begin
        r_a     <= i_a;
        r_got_a <= 1'b1;
        r_a_ack <= 1'b1;
      end
      if (i_b_stb && !r_got_b && !r_z_stb) begin
        r_b     <= i_b;
        r_got_b <= 1'b1;
        r_b_ack <= 1'b1;
      end
      if (r_got_a && r_got_b &&
          !r_run && !r_z_stb) begin
        r_run <= 1'b1;
        r_cnt <= r_a[1:0] ^ r_b[1:0];
      end
      if (r_run) begin
        if (r_cnt == 2'd0) begin
          r_z     <= w_res;
          r_z_stb <= 1'b1;
          r_run   <= 1'b0;
          r_got_a <= 1'b0;
          r_got_b <= 1'b0;
        end else begin
          r_cnt <= r_cnt - 2'd1;
        end
      end
      if (r_z_stb && i_z_ack)
        r_z_stb <= 1'b0;
    end
  end

  assign o_a_ack = r_a_ack;
  assign o_b_ack = r_b_ack;
  assign o_z     = r_z;
  assign o_z_stb = r_z_stb;

endmodule

// File: rtl/exp_taylor_unit.sv
// fp32 e^x via Horner-form Taylor series on one shared
// multiplier and one adder, valid/ready on both sides.
module exp_taylor_unit #(
  parameter int ORDER = 4,
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_flags
);
  import exp_pkg::*;

  if (ORDER < 1 || ORDER > 8) begin : g_bad_order
    $error("exp_taylor_unit: ORDER must be 1..8");
  end
  if (WIDTH != 32) begin : g_bad_width
    $error("exp_taylor_unit: WIDTH must be 32");
  end

  state_t      r_state;
  logic [31:0] r_x;
  logic [31:0] r_p;
  logic [31:0] r_t;
  logic [3:0]  r_k;
  logic [2:0]  r_flags;
  logic        r_issued;
  logic        r_mul_go;
  logic        r_add_go;
  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  logic [31:0] r_add_b;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [2:0]  r_out_flags;

  logic [31:0] w_mul_opa;
  logic [31:0] w_mul_opb;
  logic        w_mul_a_stb;
  logic        w_mul_b_stb;
  logic        w_mul_a_ack;
  logic        w_mul_b_ack;
  logic [31:0] w_mul_zu;
  logic        w_mul_z_stb;
  logic        w_mul_z_ack;
  logic [31:0] w_mul_z;
  logic        w_mul_done;

  logic [31:0] w_add_opa;
  logic [31:0] w_add_opb;
  logic        w_add_a_stb;
  logic        w_add_b_stb;
  logic        w_add_a_ack;
  logic        w_add_b_ack;
  logic [31:0] w_add_zu;
  logic        w_add_z_stb;
  logic        w_add_z_ack;
  logic [31:0] w_add_z;
  logic        w_add_done;

  logic        w_nan;
  logic        w_ovf;
  logic        w_unf;

  // Mutually exclusive so the decoder can be unique.
  assign w_nan = (r_x[30:23] == 8'hFF) &&
                 (r_x[22:0] != 23'd0);
  assign w_ovf = !w_nan && !r_x[31] &&
                 (r_x > OVF_TH);
  assign w_unf = !w_nan && r_x[31] &&
                 (r_x[30:0] > UNF_TH[30:0]);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_p         <= '0;
      r_t         <= '0;
      r_k         <= '0;
      r_flags     <= '0;
      r_issued    <= 1'b0;
      r_mul_go    <= 1'b0;
      r_add_go    <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_add_b     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_flags <= '0;
    end else begin
      r_mul_go <= 1'b0;
      r_add_go <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (r_in_ready && in_valid) begin
            r_x        <= in_data;
            r_in_ready <= 1'b0;
            r_state    <= S_CLASSIFY;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_CLASSIFY: begin
          unique case (1'b1)
            w_nan: begin
              r_p     <= QNAN;
              r_flags <= 3'b100;
              r_state <= S_DONE;
            end
            w_ovf: begin
              r_p     <= POS_INF;
              r_flags <= 3'b010;
              r_state <= S_DONE;
            end
            w_unf: begin
              r_p     <= '0;
              r_flags <= 3'b001;
              r_state <= S_DONE;
            end
            default: begin
              r_p     <= ONE;
              r_k     <= 4'(ORDER);
              r_flags <= '0;
              r_state <= S_MUL_X;
            end
          endcase
        end
        S_MUL_X: begin
          if (!r_issued) begin
            r_mul_go <= 1'b1;
            r_mul_a  <= r_x;
            r_mul_b  <= inv_rom(r_k);
            r_issued <= 1'b1;
          end else if (w_mul_done) begin
            r_t      <= w_mul_z;
            r_issued <= 1'b0;
            r_state  <= S_MUL_P;
          end
        end
        S_MUL_P: begin
          if (!r_issued) begin
            r_mul_go <= 1'b1;
            r_mul_a  <= r_t;
            r_mul_b  <= r_p;
            r_issued <= 1'b1;
          end else if (w_mul_done) begin
            r_t      <= w_mul_z;
            r_issued <= 1'b0;
            r_state  <= S_ADD_1;
          end
        end
        S_ADD_1: begin
          if (!r_issued) begin
            r_add_go <= 1'b1;
            r_add_b  <= r_t;
            r_issued <= 1'b1;
          end else if (w_add_done) begin
            r_p      <= w_add_z;
            r_k      <= r_k - 4'd1;
            r_issued <= 1'b0;
            r_state  <= (r_k == 4'd1) ?
                        S_DONE : S_MUL_X;
          end
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_p;
            r_out_flags <= r_flags;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  fp_op_seq u_mul_seq (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_go    (r_mul_go),
    .i_a     (r_mul_a),
    .i_b     (r_mul_b),
    .o_a     (w_mul_opa),
    .o_b     (w_mul_opb),
    .o_a_stb (w_mul_a_stb),
    .o_b_stb (w_mul_b_stb),
    .i_a_ack (w_mul_a_ack),
    .i_b_ack (w_mul_b_ack),
    .i_z     (w_mul_zu),
    .i_z_stb (w_mul_z_stb),
    .o_z_ack (w_mul_z_ack),
    .o_z     (w_mul_z),
    .o_done  (w_mul_done)
  );

  fp_unit #(.IS_ADD(1'b0)) u_mul (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_a     (w_mul_opa),
    .i_a_stb (w_mul_a_stb),
    .o_a_ack (w_mul_a_ack),
    .i_b     (w_mul_opb),
    .i_b_stb (w_mul_b_stb),
    .o_b_ack (w_mul_b_ack),
    .o_z     (w_mul_zu),
    .o_z_stb (w_mul_z_stb),
    .i_z_ack (w_mul_z_ack)
  );

  fp_op_seq u_add_seq (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_go    (r_add_go),
    .i_a     (ONE),
    .i_b     (r_add_b),
    .o_a     (w_add_opa),
    .o_b     (w_add_opb),
    .o_a_stb (w_add_a_stb),
    .o_b_stb (w_add_b_stb),
    .i_a_ack (w_add_a_ack),
    .i_b_ack (w_add_b_ack),
    .i_z     (w_add_zu),
    .i_z_stb (w_add_z_stb),
    .o_z_ack (w_add_z_ack),
    .o_z     (w_add_z),
    .o_done  (w_add_done)
  );

  fp_unit #(.IS_ADD(1'b1)) u_add (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_a     (w_add_opa),
    .i_a_stb (w_add_a_stb),
    .o_a_ack (w_add_a_ack),
    .i_b     (w_add_opb),
    .i_b_stb (w_add_b_stb),
    .o_b_ack (w_add_b_ack),
    .o_z     (w_add_zu),
    .o_z_stb (w_add_z_stb),
    .i_z_ack (w_add_z_ack)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_flags = r_out_flags;

endmodule
